// File: rtl/neuron_pkg.sv
// neuron_pkg: shared definitions for the neuron_mac slice.
//   state_e    - evaluation FSM states
//   clog2()    - ceiling log2 for constant width derivations
//   acc_width()- accumulator width: 2*DW-1 product bits + clog2(N) growth + 1 guard bit
package neuron_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDrain,
        StDone
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        if (value > 1) begin
            v = value - 1;
            while (v > 0) begin
                result = result + 1;
                v = v >> 1;
            end
        end
        return result;
    endfunction

    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned n);
        return 2 * dw - 1 + clog2(n) + 1;
    endfunction

endpackage

// File: rtl/sm_multiplier.sv
// sm_multiplier: sign-magnitude x sign-magnitude multiplier producing a signed
// two's-complement product through a LAT-stage register pipeline.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset (clears all stages)
//   in_valid   - operands a/b valid this cycle
//   a, b       - DW-bit sign-magnitude operands (MSB = sign)
//   out_valid  - product valid, LAT cycles after in_valid
//   product    - (2*DW-1)-bit two's-complement product
module sm_multiplier #(
    parameter int unsigned DW  = 8,
    parameter int unsigned LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic            out_valid,
    output logic [2*DW-2:0] product
);

    localparam int unsigned MW = 2 * DW - 2;  // magnitude product width
    localparam int unsigned PW = MW + 1;      // signed product width

    logic [DW-2:0] a_mag;
    logic [DW-2:0] b_mag;
    logic [MW-1:0] mag;
    logic          neg;
    logic [PW-1:0] prod_c;

    logic [PW-1:0] stage_q [LAT];
    logic [LAT-1:0] valid_q;

    always_comb begin
        a_mag  = a[DW-2:0];
        b_mag  = b[DW-2:0];
        mag    = MW'(a_mag) * MW'(b_mag);
        // A zero magnitude is always +0, so a -0 operand never yields a negative result.
        neg    = (a[DW-1] ^ b[DW-1]) && (mag != '0);
        prod_c = neg ? -{1'b0, mag} : {1'b0, mag};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            stage_q[0] <= in_valid ? prod_c : '0;
            for (int unsigned i = 1; i < LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[LAT-1];
    assign product   = stage_q[LAT-1];

endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: single-neuron multiply-accumulate with ReLU activation.
// Accepts N sign-magnitude (data, weight) pairs after a start pulse, accumulates
// their signed products, then presents the activated result with a valid/ready
// handshake.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   start      - begin an evaluation (only honoured in IDLE)
//   in_valid   - in_data/in_weight pair valid
//   in_data    - DW-bit sign-magnitude input
//   in_weight  - DW-bit sign-magnitude weight
//   in_ready   - pair accepted when high (ACCUM only)
//   out_valid  - result valid, held until out_ready
//   out_ready  - consumer accepts result
//   out_data   - OUT_W-bit unsigned activated result
//   busy       - high outside IDLE
// Build option: define NEURON_SAT_EN to saturate positive results to 2^OUT_W-1
// instead of truncating to the low OUT_W bits. Assumes OUT_W < ACC_W.
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned DW       = 8,
    parameter int unsigned MULT_LAT = 1,
    parameter int unsigned OUT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    input  logic [DW-1:0]    in_weight,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             busy
);

    localparam int unsigned ACC_W = acc_width(DW, N);
    localparam int unsigned PW    = 2 * DW - 1;
    localparam int unsigned CNT_W = (clog2(N + 1) > 0) ? clog2(N + 1) : 1;
    localparam int unsigned DRN_W = (clog2(MULT_LAT + 1) > 0) ? clog2(MULT_LAT + 1) : 1;

    state_e             state_q;
    logic [CNT_W-1:0]   beat_cnt_q;
    logic [DRN_W-1:0]   drain_cnt_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [OUT_W-1:0]   out_data_q;
    logic               busy_q;
    logic signed [ACC_W-1:0] acc_q;

    logic               beat;
    logic               last_beat;
    logic               prod_valid;
    logic [PW-1:0]      prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic [OUT_W-1:0]   act_value;

    // in_ready_q is only ever set while in ACCUM, so it qualifies the beat alone.
    assign beat      = in_valid & in_ready_q;
    assign last_beat = beat && (beat_cnt_q == CNT_W'(N - 1));

    sm_multiplier #(
        .DW  (DW),
        .LAT (MULT_LAT)
    ) u_mult (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (beat),
        .a         (in_data),
        .b         (in_weight),
        .out_valid (prod_valid),
        .product   (prod)
    );

    assign prod_ext = {{(ACC_W - PW){prod[PW-1]}}, prod};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (state_q == StIdle && start) begin
            acc_q <= '0;
        end else if (prod_valid) begin
            acc_q <= acc_q + prod_ext;
        end
    end

    // ReLU followed by width reduction.
    always_comb begin
        act_value = '0;
        if (!acc_q[ACC_W-1]) begin
`ifdef NEURON_SAT_EN
            if (|acc_q[ACC_W-1:OUT_W]) begin
                act_value = '1;
            end else begin
                act_value = acc_q[OUT_W-1:0];
            end
`else
            act_value = acc_q[OUT_W-1:0];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StAccum;
                        beat_cnt_q <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                StAccum: begin
                    if (beat) begin
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                    end
                    if (last_beat) begin
                        state_q     <= StDrain;
                        in_ready_q  <= 1'b0;
                        drain_cnt_q <= '0;
                    end
                end
                StDrain: begin
                    // MULT_LAT+1 cycles: the last product lands in acc_q on the final one.
                    if (drain_cnt_q == DRN_W'(MULT_LAT)) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                        out_data_q  <= act_value;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DRN_W'(1);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        out_data_q  <= '0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_neuron_mac.sv
module tb_neuron_mac;

    localparam int unsigned N        = 4;
    localparam int unsigned DW       = 8;
    localparam int unsigned MULT_LAT = 1;
    localparam int unsigned OUT_W    = 8;
    localparam int          OUT_MAX  = (1 << OUT_W) - 1;

    logic             clk;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic [DW-1:0]    in_data;
    logic [DW-1:0]    in_weight;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             busy;

    int checks;
    int errors;

    logic [DW-1:0] pair_d [N];
    logic [DW-1:0] pair_w [N];

    neuron_mac #(
        .N        (N),
        .DW       (DW),
        .MULT_LAT (MULT_LAT),
        .OUT_W    (OUT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_weight (in_weight),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: sign-magnitude value, dot product, ReLU, then width reduction.
    function automatic int sm_val(input logic [DW-1:0] x);
        int m;
        m = int'(x[DW-2:0]);
        return x[DW-1] ? -m : m;
    endfunction

    function automatic int model_out();
        int acc;
        acc = 0;
        for (int i = 0; i < N; i++) acc += sm_val(pair_d[i]) * sm_val(pair_w[i]);
        if (acc < 0) return 0;
`ifdef NEURON_SAT_EN
        return (acc > OUT_MAX) ? OUT_MAX : acc;
`else
        return acc % (OUT_MAX + 1);
`endif
    endfunction

    task automatic set4(input logic [7:0] d0, input logic [7:0] w0, input logic [7:0] d1,
                        input logic [7:0] w1, input logic [7:0] d2, input logic [7:0] w2,
                        input logic [7:0] d3, input logic [7:0] w3);
        pair_d[0] = d0; pair_w[0] = w0;
        pair_d[1] = d1; pair_w[1] = w1;
        pair_d[2] = d2; pair_w[2] = w2;
        pair_d[3] = d3; pair_w[3] = w3;
    endtask

    task automatic set_random();
        for (int i = 0; i < N; i++) begin
            pair_d[i] = DW'($urandom_range(0, 255));
            pair_w[i] = DW'($urandom_range(0, 255));
        end
    endtask

    // One evaluation from IDLE. gaps: random in_valid bubbles; noise: start pulses
    // outside IDLE; hold: cycles with out_ready low; accept: finish the handshake.
    task automatic run_eval(input string tag, input int exp_out, input bit gaps,
                            input int hold, input bit noise, input bit accept);
        int  beats;
        int  guard;
        int  n;
        bit  take;
        // garbage pair offered during the start cycle must not count
        in_valid  = 1'b1;
        in_data   = DW'($urandom);
        in_weight = DW'($urandom);
        start     = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "/ready_after_start"}, in_ready, 1);
        check({tag, "/busy_after_start"}, busy, 1);
        beats = 0;
        guard = 0;
        while (beats < N && guard < 200) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                in_valid  = 1'b0;
                in_data   = DW'($urandom);
                in_weight = DW'($urandom);
            end else begin
                in_valid  = 1'b1;
                in_data   = pair_d[beats];
                in_weight = pair_w[beats];
            end
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            take  = in_valid && in_ready;
            tick();
            if (take) beats++;
            guard++;
        end
        check({tag, "/beats_accepted"}, beats, N);
        in_valid = 1'b1;
        in_data  = DW'($urandom);
        start    = noise;
        check({tag, "/ready_low_after_last"}, in_ready, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check({tag, "/latency_cycles"}, n + 1, MULT_LAT + 2);
        check({tag, "/out_data"}, out_data, exp_out);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            start = noise;
            tick();
            check({tag, "/hold_valid"}, out_valid, 1);
            check({tag, "/hold_data"}, out_data, exp_out);
            check({tag, "/hold_busy"}, busy, 1);
        end
        start = 1'b0;
        if (accept) begin
            out_ready = 1'b1;
            start     = noise;
            tick();
            out_ready = 1'b0;
            start     = 1'b0;
            check({tag, "/valid_after_accept"}, out_valid, 0);
            check({tag, "/busy_after_accept"}, busy, 0);
            check({tag, "/ready_after_accept"}, in_ready, 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/in_ready"}, in_ready, 0);
        check({tag, "/out_valid"}, out_valid, 0);
        check({tag, "/out_data"}, out_data, 0);
        check({tag, "/busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_weight = '0;
        out_ready = 1'b0;
        #2;
        check_reset_outputs("reset_state");
        tick();
        tick();
        rst = 1'b0;

        // in_valid in IDLE has no effect
        in_valid = 1'b1;
        in_data  = 8'd5;
        tick();
        tick();
        check("idle_in_valid/busy", busy, 0);
        check("idle_in_valid/in_ready", in_ready, 0);
        in_valid = 1'b0;

        // back-to-back basic evaluation
        set4(8'd3, 8'd2, 8'd4, 8'd5, 8'd1, 8'd1, 8'd0, 8'd7);
        run_eval("basic27", 27, 0, 0, 0, 1);

        // negative sum clamps to zero
        set4(8'h85, 8'd2, 8'd3, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1);
        run_eval("relu_neg", 0, 0, 1, 0, 1);

        // large positive sum: saturate or wrap
        set4(8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127);
`ifdef NEURON_SAT_EN
        run_eval("big_sum", 255, 0, 0, 0, 1);
`else
        run_eval("big_sum", 8'h04, 0, 0, 0, 1);
`endif

        // -0 operand, negative weight, gaps, back-pressure
        set4(8'h80, 8'd9, 8'd2, 8'h82, 8'd10, 8'd1, 8'd1, 8'd1);
        run_eval("gaps_hold", 7, 1, 5, 0, 1);

        // start pulses in ACCUM, DRAIN, DONE and the acceptance cycle are ignored
        set4(8'd3, 8'd2, 8'd4, 8'd5, 8'd1, 8'd1, 8'd0, 8'd7);
        run_eval("start_noise", 27, 1, 3, 1, 1);

        // asynchronous reset after two beats discards the partial sum
        set_random();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid  = 1'b1;
            in_data   = pair_d[i];
            in_weight = pair_w[i];
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("abort_async");
        tick();
        rst = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'd1;
        in_weight = 8'd1;
        tick();
        tick();
        tick();
        check("abort_needs_start/in_ready", in_ready, 0);
        check("abort_needs_start/busy", busy, 0);
        in_valid = 1'b0;
        set4(8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1);
        run_eval("abort_rerun", 4, 0, 0, 0, 1);

        // asynchronous reset while a result is pending
        set4(8'd3, 8'd2, 8'd4, 8'd5, 8'd1, 8'd1, 8'd0, 8'd7);
        run_eval("done_pending", 27, 0, 2, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("done_async");
        tick();
        rst = 1'b0;
        tick();

        // randomized evaluations against the reference model
        for (int r = 0; r < 8; r++) begin
            set_random();
            run_eval($sformatf("rand%0d", r), model_out(), 1, $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/neuron_mac.md
NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 Parameter N, default 4, number of input/weight pairs per neuron evaluation (N >= 1).
REQ-002 Parameter DW, default 8, width of sign-magnitude input and weight words (MSB = sign).
REQ-003 Parameter MULT_LAT, default 1, multiplier pipeline depth in cycles (>= 1).
REQ-004 Parameter OUT_W, default 8, activation output width; ACC_W = 2*DW-1 + clog2(N) + 1 internal two's-complement accumulator width.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  begin a new evaluation (sampled only in IDLE).
REQ-008 in_valid  in  1  in_data/in_weight pair valid.
REQ-009 in_data  in  DW  sign-magnitude input.
REQ-010 in_weight  in  DW  sign-magnitude weight.
REQ-011 in_ready  out  1  high only in ACCUM.
REQ-012 out_valid  out  1  result valid, held until accepted.
REQ-013 out_ready  in  1  consumer accepts result.
REQ-014 out_data  out  OUT_W  activated result, unsigned.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 FSM states IDLE, ACCUM, DRAIN, DONE; start in IDLE clears accumulator and beat counter, next state ACCUM; start outside IDLE ignored.
REQ-017 In ACCUM a beat is in_valid & in_ready; counter increments per beat; on the N-th beat next state DRAIN, in_ready low from the next cycle.
REQ-018 Product magnitude = unsigned product of DW-1 magnitude bits; product sign = XOR of sign bits; magnitude zero gives +0 regardless of sign (-0 inputs treated as 0).
REQ-019 Signed product converted to ACC_W two's complement and added to accumulator MULT_LAT+1 cycles after its beat; accumulator never overflows by construction.
REQ-020 DRAIN lasts exactly MULT_LAT+1 cycles so the last product is included; then DONE with out_valid high.
REQ-021 out_valid first asserts MULT_LAT+2 cycles after the cycle of the N-th beat accepted.
REQ-022 Activation is ReLU: negative accumulator gives out_data 0, else accumulator value reduced to OUT_W per REQ-027/028.
REQ-023 DONE with out_ready high returns to IDLE next cycle; out_data/out_valid stable while out_ready low; start in the acceptance cycle ignored.
REQ-024 in_valid while not in ACCUM has no effect; idle gaps in ACCUM do not alter counter or accumulator.

Reset
REQ-025 rst asserted at any time, including mid-evaluation, forces IDLE, counter 0, accumulator 0, pipeline registers 0, in_ready 0, out_valid 0, out_data 0, busy 0, within the same cycle without waiting for clk.
REQ-026 First evaluation after rst deassertion needs a fresh start; partial results are discarded.

Configuration
REQ-027 With NEURON_SAT_EN defined, a non-negative accumulator above 2^OUT_W-1 yields out_data = 2^OUT_W-1.
REQ-028 Without NEURON_SAT_EN, out_data = accumulator bits [OUT_W-1:0] (truncation, wrap-around).

Structure
REQ-029 Package neuron_pkg holds the FSM state enum, the clog2 function, and the ACC_W derivation.
REQ-030 One sub-module sm_multiplier (sign-magnitude to signed two's-complement, MULT_LAT-stage pipeline) instantiated once; FSM, counter, accumulator and activation live in neuron_mac.

Verification (defaults N=4, DW=8, MULT_LAT=1, OUT_W=8)
REQ-031 Pairs (3,2),(4,5),(1,1),(0,7) back-to-back -> out_data 27, out_valid 3 cycles after 4th beat.
REQ-032 Pairs (0x85,2),(3,1),(1,1),(1,1) i.e. -5*2+5 -> accumulator -5, out_data 0.
REQ-033 Four pairs (127,127) -> accumulator 64516; with NEURON_SAT_EN out_data 255, without out_data 0x04.
REQ-034 Pairs (0x80,9),(2,0x82),(10,1),(1,1) with in_valid gaps and out_ready held low 5 cycles -> out_data 7 held stable, busy high until accept.
REQ-035 rst pulse after 2nd beat then full new evaluation of four (1,1) -> out_data 4, no residue from aborted run.
REQ-036 start pulses during ACCUM and DONE -> ignored; beat count and result unchanged.
